// File: rtl/wb_exc_stage_pkg.sv
// Shared writeback/exception definitions for the WB stage and the CSR unit.
// Package name wb_pkg is imported by the WB-stage files and by the CSR unit.
package wb_pkg;

  typedef enum logic {
    WB_RUN   = 1'b0,
    WB_REDIR = 1'b1
  } wb_state_e;

  // Bit positions inside in_exc = {adef, ine, sys, brk, ale}
  localparam int EXC_W    = 5;
  localparam int EXC_ADEF = 4;
  localparam int EXC_INE  = 3;
  localparam int EXC_SYS  = 2;
  localparam int EXC_BRK  = 1;
  localparam int EXC_ALE  = 0;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0b;
  localparam logic [5:0] ECODE_BRK  = 6'h0c;
  localparam logic [5:0] ECODE_INE  = 6'h0d;

  typedef struct packed {
    logic intr;
    logic adef;
    logic ine;
    logic sys;
    logic brk;
    logic ale;
  } exc_onehot_t;

  typedef struct packed {
    logic [31:0]      pc;
    logic [EXC_W-1:0] exc;
    logic [31:0]      badaddr;
    logic             is_ertn;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;
    logic             csr_we;
    logic [13:0]      csr_addr;
    logic [31:0]      csr_wdata;
  } wb_entry_t;

  // Ecode for a one-hot cause report; the CSR unit uses this to fill ESTAT.
  function automatic logic [5:0] exc_ecode(input exc_onehot_t oh);
    logic [5:0] code;
    code = ECODE_INT;
    if (oh.adef)     code = ECODE_ADEF;
    else if (oh.ine) code = ECODE_INE;
    else if (oh.sys) code = ECODE_SYS;
    else if (oh.brk) code = ECODE_BRK;
    else if (oh.ale) code = ECODE_ALE;
    return code;
  endfunction

endpackage

// File: rtl/wb_exc_stage_if.sv
// MEM->WB transfer bus: valid/ready handshake plus the retiring instruction payload.
interface wb_exc_stage_if;
  import wb_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [EXC_W-1:0] in_exc;
  logic [31:0]      in_badaddr;
  logic             in_is_ertn;
  logic             in_rf_we;
  logic [4:0]       in_rf_waddr;
  logic [31:0]      in_rf_wdata;
  logic             in_csr_we;
  logic [13:0]      in_csr_addr;
  logic [31:0]      in_csr_wdata;

  modport master (
    output in_valid, in_pc, in_exc, in_badaddr, in_is_ertn,
           in_rf_we, in_rf_waddr, in_rf_wdata,
           in_csr_we, in_csr_addr, in_csr_wdata,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_exc, in_badaddr, in_is_ertn,
           in_rf_we, in_rf_waddr, in_rf_wdata,
           in_csr_we, in_csr_addr, in_csr_wdata,
    output in_ready
  );
endinterface

// File: rtl/wb_exc_stage_exc_prio_enc.sv
// Combinational cause resolver: {interrupt, in_exc} -> one-hot report + any-exception flag.
// Priority high->low: interrupt, adef, ine, sys, brk, ale.
module exc_prio_enc
  import wb_pkg::*;
(
  input  logic             int_pending_i,
  input  logic [EXC_W-1:0] exc_i,
  output exc_onehot_t      onehot_o,
  output logic             any_exc_o
);

  always_comb begin
    // NOTE: default every output first so no path through the chain infers a latch.
    onehot_o = '0;
    if (int_pending_i)       onehot_o.intr = 1'b1;
    else if (exc_i[EXC_ADEF]) onehot_o.adef = 1'b1;
    else if (exc_i[EXC_INE])  onehot_o.ine  = 1'b1;
    else if (exc_i[EXC_SYS])  onehot_o.sys  = 1'b1;
    else if (exc_i[EXC_BRK])  onehot_o.brk  = 1'b1;
    else if (exc_i[EXC_ALE])  onehot_o.ale  = 1'b1;
  end

  assign any_exc_o = int_pending_i | (|exc_i);

endmodule

// File: rtl/wb_exc_stage.sv
// LoongArch writeback stage: retires one instruction per cycle, reports exceptions/ertn
// to the CSR unit and holds a fetch redirect. Optional trace ports under `WB_TRACE_EN.
module wb_exc_stage
  import wb_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  wb_exc_stage_if.slave       mem_wb,
  input  logic                int_pending,
  input  logic [31:0]         csr_exc_pc,
  input  logic [31:0]         csr_quit_pc,
  output logic                MEM_WB_valid,
  output logic                is_interrupt,
  output logic                is_adef,
  output logic                is_ine,
  output logic                is_sys,
  output logic                is_break,
  output logic                is_ale,
  output logic                is_ertn,
  output logic [31:0]         exc_in_pc,
  output logic [31:0]         ale_in_pc,
  output logic                rf_we,
  output logic [4:0]          rf_waddr,
  output logic [31:0]         rf_wdata,
  output logic                csr_we,
  output logic [13:0]         csr_addr,
  output logic [31:0]         csr_wdata,
  output logic                flush,
  output logic                redirect_valid,
  input  logic                redirect_ready,
  output logic [31:0]         redirect_pc
`ifdef WB_TRACE_EN
  ,
  output logic [31:0]         debug_wb_pc,
  output logic [3:0]          debug_wb_rf_we,
  output logic [4:0]          debug_wb_rf_wnum,
  output logic [31:0]         debug_wb_rf_wdata
`endif
);

  localparam logic [0:0] RUN   = WB_RUN;
  localparam logic [0:0] REDIR = WB_REDIR;

  logic [0:0]  state_q, state_d;
  logic        wb_valid_q, wb_valid_d;
  wb_entry_t   wb_q, wb_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  exc_onehot_t exc_oh;
  logic        any_exc;
  logic        int_gated;
  logic        exc_hit;
  logic        ertn_hit;
  logic        trap;
  logic        in_run;

  assign in_run = (state_q == RUN);

  // The interrupt only ever attaches to a live instruction, never to a bubble or a redirect.
  assign int_gated = int_pending & wb_valid_q & in_run;

  exc_prio_enc u_exc_prio_enc (
    .int_pending_i (int_gated),
    .exc_i         (wb_q.exc),
    .onehot_o      (exc_oh),
    .any_exc_o     (any_exc)
  );

  assign exc_hit  = wb_valid_q & any_exc;
  assign ertn_hit = wb_valid_q & wb_q.is_ertn & ~any_exc;
  assign trap     = exc_hit | ertn_hit;

  always_comb begin
    state_d       = state_q;
    wb_valid_d    = 1'b0;
    wb_d          = wb_q;
    redirect_pc_d = redirect_pc_q;
    if (state_q == REDIR) begin
      if (redirect_ready) state_d = RUN;
    end else if (trap) begin
      // ERA is sampled here, before the CSR unit commits this ertn/exception.
      state_d       = REDIR;
      redirect_pc_d = exc_hit ? csr_exc_pc : csr_quit_pc;
    end else if (mem_wb.in_valid) begin
      wb_valid_d = 1'b1;
      wb_d       = '{pc:        mem_wb.in_pc,
                     exc:       mem_wb.in_exc,
                     badaddr:   mem_wb.in_badaddr,
                     is_ertn:   mem_wb.in_is_ertn,
                     rf_we:     mem_wb.in_rf_we,
                     rf_waddr:  mem_wb.in_rf_waddr,
                     rf_wdata:  mem_wb.in_rf_wdata,
                     csr_we:    mem_wb.in_csr_we,
                     csr_addr:  mem_wb.in_csr_addr,
                     csr_wdata: mem_wb.in_csr_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wb_valid_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      wb_valid_q    <= wb_valid_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // NOTE: the payload is qualified by wb_valid_q everywhere, so it carries no reset.
  always_ff @(posedge clk) begin
    wb_q <= wb_d;
  end

  assign mem_wb.in_ready = in_run;
  assign MEM_WB_valid    = wb_valid_q;

  assign is_interrupt = wb_valid_q & exc_oh.intr;
  assign is_adef      = wb_valid_q & exc_oh.adef;
  assign is_ine       = wb_valid_q & exc_oh.ine;
  assign is_sys       = wb_valid_q & exc_oh.sys;
  assign is_break     = wb_valid_q & exc_oh.brk;
  assign is_ale       = wb_valid_q & exc_oh.ale;
  assign is_ertn      = ertn_hit;

  assign exc_in_pc = wb_q.pc;
  assign ale_in_pc = wb_q.badaddr;

  assign rf_we     = wb_valid_q & wb_q.rf_we & ~trap;
  assign rf_waddr  = wb_q.rf_waddr;
  assign rf_wdata  = wb_q.rf_wdata;
  assign csr_we    = wb_valid_q & wb_q.csr_we & ~trap;
  assign csr_addr  = wb_q.csr_addr;
  assign csr_wdata = wb_q.csr_wdata;

  assign flush          = trap | (state_q == REDIR);
  assign redirect_valid = (state_q == REDIR);
  assign redirect_pc    = redirect_pc_q;

`ifdef WB_TRACE_EN
  assign debug_wb_pc       = wb_q.pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_exc_stage.sv
// Self-checking bench for wb_exc_stage: directed vector table, hand-written redirect/reset
// sequences, and a randomized phase against a behavioural cause/redirect model.
module tb_wb_exc_stage;
  import wb_pkg::*;

  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_INT  = 7'b1000000;
  localparam logic [6:0] F_ADEF = 7'b0100000;
  localparam logic [6:0] F_INE  = 7'b0010000;
  localparam logic [6:0] F_SYS  = 7'b0001000;
  localparam logic [6:0] F_BRK  = 7'b0000100;
  localparam logic [6:0] F_ALE  = 7'b0000010;
  localparam logic [6:0] F_ERTN = 7'b0000001;
  localparam logic [31:0] EENTRY = 32'h1c008000;
  localparam logic [31:0] ERA    = 32'h1c000104;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_exc_stage_if mem ();

  logic        int_pending, redirect_ready;
  logic [31:0] csr_exc_pc, csr_quit_pc;
  logic        mem_wb_valid, is_interrupt, is_adef, is_ine, is_sys, is_break, is_ale, is_ertn;
  logic [31:0] exc_in_pc, ale_in_pc, rf_wdata, csr_wdata, redirect_pc;
  logic        rf_we, csr_we, flush, redirect_valid;
  logic [4:0]  rf_waddr;
  logic [13:0] csr_addr;
  logic [6:0]  flags;
`ifdef WB_TRACE_EN
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
`endif

  assign flags = {is_interrupt, is_adef, is_ine, is_sys, is_break, is_ale, is_ertn};

  wb_exc_stage dut (
    .clk            (clk),
    .reset          (reset),
    .mem_wb         (mem.slave),
    .int_pending    (int_pending),
    .csr_exc_pc     (csr_exc_pc),
    .csr_quit_pc    (csr_quit_pc),
    .MEM_WB_valid   (mem_wb_valid),
    .is_interrupt   (is_interrupt),
    .is_adef        (is_adef),
    .is_ine         (is_ine),
    .is_sys         (is_sys),
    .is_break       (is_break),
    .is_ale         (is_ale),
    .is_ertn        (is_ertn),
    .exc_in_pc      (exc_in_pc),
    .ale_in_pc      (ale_in_pc),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .csr_we         (csr_we),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc)
`ifdef WB_TRACE_EN
    ,
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] exc,
                       input logic [31:0] bad, input logic ertn, input logic rwe,
                       input logic [4:0] wa, input logic [31:0] wd, input logic cwe);
    mem.in_valid     = v;
    mem.in_pc        = pc;
    mem.in_exc       = exc;
    mem.in_badaddr   = bad;
    mem.in_is_ertn   = ertn;
    mem.in_rf_we     = rwe;
    mem.in_rf_waddr  = wa;
    mem.in_rf_wdata  = wd;
    mem.in_csr_we    = cwe;
    mem.in_csr_addr  = 14'h0006;
    mem.in_csr_wdata = ~wd;
  endtask

  // Behavioural cause resolution: walk the causes in priority order, then fall back to ertn.
  function automatic logic [6:0] exp_flags(input logic valid, input logic [4:0] exc,
                                           input logic ertn, input logic intp);
    logic [5:0] causes;
    if (!valid) return F_NONE;
    causes = {intp, exc};
    for (int i = 5; i >= 0; i--)
      if (causes[i]) return 7'(1) << (i + 1);
    return ertn ? F_ERTN : F_NONE;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  exc;
    logic [31:0] bad;
    logic        ertn;
    logic        rwe;
    logic        cwe;
    logic        intp;
    logic [6:0]  e_flags;
    logic        e_rwe;
    logic        e_cwe;
    logic        e_flush;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vecs[10];

  // One instruction through WB; on a trap also walk the redirect handshake.
  task automatic apply(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    int_pending = 1'b0;
    redirect_ready = 1'b0;
    drive(1'b1, v.pc, v.exc, v.bad, v.ertn, v.rwe, 5'd9, v.pc ^ 32'h5a5a0000, v.cwe);
    next_cycle();
    mem.in_valid = 1'b0;
    int_pending = v.intp;
    #1;
    check({tag, " flags"}, 32'(flags), 32'(v.e_flags));
    check({tag, " rf_we"}, 32'(rf_we), 32'(v.e_rwe));
    check({tag, " csr_we"}, 32'(csr_we), 32'(v.e_cwe));
    check({tag, " flush"}, 32'(flush), 32'(v.e_flush));
    check({tag, " exc_in_pc"}, exc_in_pc, v.pc);
    check({tag, " ale_in_pc"}, ale_in_pc, v.bad);
    check({tag, " MEM_WB_valid"}, 32'(mem_wb_valid), 32'd1);
    check({tag, " rf_wdata"}, rf_wdata, v.pc ^ 32'h5a5a0000);
    next_cycle();
    int_pending = 1'b0;
    if (v.e_flush) begin
      check({tag, " redirect_valid"}, 32'(redirect_valid), 32'd1);
      check({tag, " redirect_pc"}, redirect_pc, v.e_rpc);
      check({tag, " in_ready in REDIR"}, 32'(mem.in_ready), 32'd0);
      redirect_ready = 1'b1;
      next_cycle();
      redirect_ready = 1'b0;
    end
    check({tag, " back in RUN"}, 32'(mem.in_ready), 32'd1);
    check({tag, " redirect_valid low"}, 32'(redirect_valid), 32'd0);
  endtask

  // Reference-model state for the randomized phase
  logic        m_valid, m_redir, m_ertn, m_rwe, m_cwe;
  logic [4:0]  m_exc;
  logic [31:0] m_pc, m_wd, m_rpc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h1c000010, 5'b00000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, F_NONE, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{32'h1c000020, 5'b00100, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, F_SYS,  1'b0, 1'b0, 1'b1, EENTRY};
    vecs[2] = '{32'h1c000024, 5'b10001, 32'h8, 1'b0, 1'b1, 1'b0, 1'b1, F_INT,  1'b0, 1'b0, 1'b1, EENTRY};
    vecs[3] = '{32'h1c000030, 5'b00000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, F_ERTN, 1'b0, 1'b0, 1'b1, ERA};
    vecs[4] = '{32'h1c000030, 5'b01000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, F_INE,  1'b0, 1'b0, 1'b1, EENTRY};
    vecs[5] = '{32'h1c000040, 5'b00001, 32'h3, 1'b0, 1'b1, 1'b0, 1'b0, F_ALE,  1'b0, 1'b0, 1'b1, EENTRY};
    vecs[6] = '{32'h1c000044, 5'b00010, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, F_BRK,  1'b0, 1'b0, 1'b1, EENTRY};
    vecs[7] = '{32'h1c000048, 5'b00000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, F_NONE, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[8] = '{32'h1c00004c, 5'b00000, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, F_INT,  1'b0, 1'b0, 1'b1, EENTRY};
    vecs[9] = '{32'h1c000050, 5'b01110, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, F_INE,  1'b0, 1'b0, 1'b1, EENTRY};

    reset = 1'b1;
    int_pending = 1'b0;
    redirect_ready = 1'b0;
    csr_exc_pc = EENTRY;
    csr_quit_pc = ERA;
    drive(1'b0, 32'h0, 5'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    next_cycle();
    next_cycle();
    check("reset MEM_WB_valid", 32'(mem_wb_valid), 32'd0);
    check("reset flags", 32'(flags), 32'd0);
    check("reset redirect_valid", 32'(redirect_valid), 32'd0);
    check("reset redirect_pc", redirect_pc, 32'd0);
    check("reset flush", 32'(flush), 32'd0);
    check("reset rf_we", 32'(rf_we), 32'd0);
    check("reset csr_we", 32'(csr_we), 32'd0);
    check("reset in_ready", 32'(mem.in_ready), 32'd1);
    reset = 1'b0;
    next_cycle();

    for (int i = 0; i < 10; i++) apply(i, vecs[i]);

    // Back-to-back retirement at full rate
    drive(1'b1, 32'h1c000010, 5'b0, 32'h0, 1'b0, 1'b1, 5'd5, 32'h00001234, 1'b0);
    next_cycle();
    drive(1'b1, 32'h1c000014, 5'b0, 32'h0, 1'b0, 1'b1, 5'd6, 32'h00005678, 1'b0);
    #1;
    check("b2b in_ready", 32'(mem.in_ready), 32'd1);
    check("b2b rf_we 1st", 32'(rf_we), 32'd1);
    check("b2b waddr 1st", 32'(rf_waddr), 32'd5);
    check("b2b wdata 1st", rf_wdata, 32'h00001234);
    check("b2b flush 1st", 32'(flush), 32'd0);
    next_cycle();
    mem.in_valid = 1'b0;
    #1;
    check("b2b rf_we 2nd", 32'(rf_we), 32'd1);
    check("b2b waddr 2nd", 32'(rf_waddr), 32'd6);
    check("b2b wdata 2nd", rf_wdata, 32'h00005678);
    check("b2b pc 2nd", exc_in_pc, 32'h1c000014);
    next_cycle();
    check("b2b drained", 32'(mem_wb_valid), 32'd0);

    // Syscall with fetch stalling the redirect for three cycles
    drive(1'b1, 32'h1c000020, 5'b00100, 32'h0, 1'b0, 1'b1, 5'd7, 32'hdead0000, 1'b0);
    next_cycle();
    mem.in_valid = 1'b0;
    #1;
    check("hold is_sys", 32'(flags), 32'(F_SYS));
    check("hold rf_we", 32'(rf_we), 32'd0);
    check("hold trap flush", 32'(flush), 32'd1);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      mem.in_valid = 1'b1;
      csr_exc_pc = 32'h0bad0000;
      int_pending = 1'b1;
      #1;
      check($sformatf("hold%0d redirect_valid", i), 32'(redirect_valid), 32'd1);
      check($sformatf("hold%0d redirect_pc", i), redirect_pc, EENTRY);
      check($sformatf("hold%0d in_ready", i), 32'(mem.in_ready), 32'd0);
      check($sformatf("hold%0d flush", i), 32'(flush), 32'd1);
      check($sformatf("hold%0d flags", i), 32'(flags), 32'd0);
      next_cycle();
    end
    redirect_ready = 1'b1;
    #1;
    check("hold release redirect_valid", 32'(redirect_valid), 32'd1);
    next_cycle();
    redirect_ready = 1'b0;
    mem.in_valid = 1'b0;
    int_pending = 1'b0;
    csr_exc_pc = EENTRY;
    #1;
    check("hold resumed in_ready", 32'(mem.in_ready), 32'd1);
    check("hold resumed redirect_valid", 32'(redirect_valid), 32'd0);
    check("hold nothing captured", 32'(mem_wb_valid), 32'd0);

    // redirect_ready already high in the first REDIR cycle
    redirect_ready = 1'b1;
    drive(1'b1, 32'h1c000060, 5'b00010, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    next_cycle();
    mem.in_valid = 1'b0;
    next_cycle();
    check("fast redirect_valid", 32'(redirect_valid), 32'd1);
    next_cycle();
    check("fast back in RUN", 32'(redirect_valid), 32'd0);
    check("fast in_ready", 32'(mem.in_ready), 32'd1);
    redirect_ready = 1'b0;

    // Reset while a redirect is pending
    drive(1'b1, 32'h1c000070, 5'b00100, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    next_cycle();
    mem.in_valid = 1'b0;
    next_cycle();
    check("rst-redir pending", 32'(redirect_valid), 32'd1);
    reset = 1'b1;
    next_cycle();
    check("rst-redir redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst-redir in_ready", 32'(mem.in_ready), 32'd1);
    check("rst-redir flush", 32'(flush), 32'd0);
    check("rst-redir redirect_pc", redirect_pc, 32'd0);
    reset = 1'b0;
    next_cycle();

    // Randomized traffic against the reference model
    m_valid = 1'b0;
    m_redir = 1'b0;
    m_rpc = 32'h0;
    m_exc = 5'b0; m_ertn = 1'b0; m_rwe = 1'b0; m_cwe = 1'b0; m_pc = 32'h0; m_wd = 32'h0;
    for (int n = 0; n < 400; n++) begin
      logic [6:0] e;
      logic       trap;
      drive(($urandom_range(3) != 0), $urandom,
            ($urandom_range(3) == 0) ? 5'($urandom) : 5'b0, $urandom,
            ($urandom_range(7) == 0), $urandom_range(1), 5'($urandom), $urandom,
            $urandom_range(1));
      int_pending = ($urandom_range(7) == 0);
      redirect_ready = $urandom_range(1);
      csr_exc_pc = $urandom;
      csr_quit_pc = $urandom;
      #1;
      e = exp_flags(m_valid, m_exc, m_ertn, int_pending);
      trap = (e != F_NONE);
      check($sformatf("rnd%0d flags", n), 32'(flags), 32'(e));
      check($sformatf("rnd%0d in_ready", n), 32'(mem.in_ready), 32'(!m_redir));
      check($sformatf("rnd%0d rf_we", n), 32'(rf_we), 32'(m_valid && m_rwe && !trap));
      check($sformatf("rnd%0d csr_we", n), 32'(csr_we), 32'(m_valid && m_cwe && !trap));
      check($sformatf("rnd%0d flush", n), 32'(flush), 32'(trap || m_redir));
      check($sformatf("rnd%0d redirect_valid", n), 32'(redirect_valid), 32'(m_redir));
      check($sformatf("rnd%0d MEM_WB_valid", n), 32'(mem_wb_valid), 32'(m_valid));
      if (m_redir) check($sformatf("rnd%0d redirect_pc", n), redirect_pc, m_rpc);
      if (m_valid) begin
        check($sformatf("rnd%0d exc_in_pc", n), exc_in_pc, m_pc);
        check($sformatf("rnd%0d rf_wdata", n), rf_wdata, m_wd);
      end
      if (m_redir) begin
        if (redirect_ready) m_redir = 1'b0;
        m_valid = 1'b0;
      end else if (trap) begin
        m_redir = 1'b1;
        m_rpc = (e == F_ERTN) ? csr_quit_pc : csr_exc_pc;
        m_valid = 1'b0;
      end else begin
        m_valid = mem.in_valid;
        m_pc = mem.in_pc;
        m_exc = mem.in_exc;
        m_ertn = mem.in_is_ertn;
        m_rwe = mem.in_rf_we;
        m_cwe = mem.in_csr_we;
        m_wd = mem.in_rf_wdata;
      end
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
